conv_job_scheduler: RTL and testbench

CONV_JOB_SCHEDULER -- requirements
Module: conv_job_scheduler

---
 rtl/conv_job_scheduler_if.sv | 28 ++
 rtl/conv_job_scheduler.sv | 125 ++++++++++++
 tb/tb_conv_job_scheduler.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_job_scheduler_if.sv
// Handshake bundle between the frame requesters, the convolution engine and the job scheduler.
interface conv_job_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [2:0]         src_sel;
  logic               conv_start;
  logic               conv_valid;
  logic [NUM_REQ-1:0] done;
  logic               err_timeout;
  logic [2:0]         err_id;
  logic               busy;
  logic [15:0]        jobs_done;
  logic [7:0]         timeouts;

  // Scheduler side.
  modport slave (
    input  req, conv_valid,
    output gnt, src_sel, conv_start, done, err_timeout, err_id, busy, jobs_done, timeouts
  );

  // Requester/engine side.
  modport master (
    output req, conv_valid,
    input  gnt, src_sel, conv_start, done, err_timeout, err_id, busy, jobs_done, timeouts
  );
endinterface

// File: rtl/conv_job_scheduler.sv
// Round-robin job scheduler sharing one convolution engine among NUM_REQ requesters,
// with a completion watchdog and job/timeout statistics.
module conv_job_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input logic                  clk,
  input logic                  rst,
  conv_job_scheduler_if.slave  bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StDone  = 3'd3;
  localparam logic [2:0] StErr   = 3'd4;

  localparam logic [15:0] TimerLast = 16'(TIMEOUT - 1);
  localparam logic [2:0]  PtrInit   = 3'(NUM_REQ - 1);

  logic [2:0]         state_q, state_d;
  logic [15:0]        timer_q, timer_d;
  logic [2:0]         sel_q;
  logic [2:0]         ptr_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [2:0]         err_id_q;
  logic [15:0]        jobs_q;
  logic [7:0]         tmo_q;

  logic [7:0]         req_ext;
  logic [3:0]         sum;
  logic [2:0]         idx;
  logic [2:0]         win;
  logic               found;

  // Rotating-priority search: first requester set at or after ptr+1, wrapping at NUM_REQ.
  always_comb begin
    req_ext = '0;
    req_ext[NUM_REQ-1:0] = bus.req;
    sum   = '0;
    idx   = '0;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      sum = {1'b0, ptr_q} + 4'(i);
      idx = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : 3'(sum);
      if (!found && req_ext[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state and watchdog timer; conv_valid only matters while waiting.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      StIdle:  if (|bus.req) state_d = StStart;
      StStart: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.conv_valid) begin
          state_d = StDone;
        end else if (timer_q == TimerLast) begin
          state_d = StErr;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, grant, pointer and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      sel_q    <= '0;
      ptr_q    <= PtrInit;
      gnt_q    <= '0;
      err_id_q <= '0;
      jobs_q   <= '0;
      tmo_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (state_q == StIdle && found) begin
        sel_q <= win;
        gnt_q <= NUM_REQ'(1) << win;
      end
      if (state_q == StDone || state_q == StErr) begin
        gnt_q <= '0;
      end
      if (state_q == StWait && state_d == StDone) begin
        ptr_q  <= sel_q;
        jobs_q <= jobs_q + 16'd1;
      end
      if (state_q == StWait && state_d == StErr) begin
        ptr_q    <= sel_q;
        err_id_q <= sel_q;
        if (tmo_q != 8'hFF) tmo_q <= tmo_q + 8'd1;
      end
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.gnt         = gnt_q;
    bus.src_sel     = sel_q;
    bus.conv_start  = (state_q == StStart);
    bus.done        = (state_q == StDone) ? gnt_q : '0;
    bus.err_timeout = (state_q == StErr);
    bus.err_id      = err_id_q;
    bus.busy        = (state_q != StIdle);
    bus.jobs_done   = jobs_q;
    bus.timeouts    = tmo_q;
  end

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Bench for conv_job_scheduler: cycle-level job model compared every cycle, plus directed scenarios.
module tb_conv_job_scheduler;
  localparam int N  = 4;
  localparam int TO = 16;

  logic clk;
  logic rst;
  conv_job_scheduler_if #(.NUM_REQ(N)) bus ();

  conv_job_scheduler #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Job-level model: an active job has an age (0 = start cycle) and an ending kind.
  int m_active, m_sel, m_age, m_end, m_ptr, m_jobs, m_tmo, m_errid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model update on each rising edge using the inputs the DUT samples there.
  initial begin
    m_active = 0; m_sel = 0; m_age = 0; m_end = 0;
    m_ptr = N - 1; m_jobs = 0; m_tmo = 0; m_errid = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_active = 0; m_sel = 0; m_age = 0; m_end = 0;
        m_ptr = N - 1; m_jobs = 0; m_tmo = 0; m_errid = 0;
      end else if (m_active == 0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (m_active == 0 && ((bus.req >> c) & 4'd1) != 0) begin
            m_active = 1; m_sel = c; m_age = 0; m_end = 0;
          end
        end
      end else if (m_end != 0) begin
        m_active = 0;
        m_end    = 0;
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (bus.conv_valid) begin
        m_end  = 1;
        m_ptr  = m_sel;
        m_jobs = (m_jobs + 1) & 16'hFFFF;
      end else if (m_age - 1 == TO - 1) begin
        m_end   = 2;
        m_ptr   = m_sel;
        m_errid = m_sel;
        m_tmo   = (m_tmo < 255) ? m_tmo + 1 : 255;
      end else begin
        m_age++;
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  initial begin
    logic [63:0] e, a;
    logic [3:0]  eg, ed;
    logic        ecs, eerr, ebusy;
    forever begin
      @(negedge clk);
      if (rst) begin
        e = '0;
      end else begin
        eg    = (m_active != 0) ? 4'(1 << m_sel) : 4'd0;
        ecs   = (m_active != 0 && m_end == 0 && m_age == 0);
        ed    = (m_end == 1) ? 4'(1 << m_sel) : 4'd0;
        eerr  = (m_end == 2);
        ebusy = (m_active != 0);
        e = {23'd0, eg, 3'(m_sel), ecs, ed, eerr, 3'(m_errid), ebusy, 16'(m_jobs), 8'(m_tmo)};
      end
      a = {23'd0, bus.gnt, bus.src_sel, bus.conv_start, bus.done, bus.err_timeout, bus.err_id,
           bus.busy, bus.jobs_done, bus.timeouts};
      chk("cycle_outputs", a, e);
    end
  end

  task automatic wait_start();
    bit ok;
    ok = 0;
    for (int n = 0; n < 60; n++) begin
      if (bus.conv_start) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) chk("start_wait_expired", 64'd0, 64'd1);
  endtask

  // From the start cycle: conv_valid is high lat cycles later, done follows one cycle after.
  task automatic finish_job(input int lat, input logic [3:0] exp_done);
    for (int n = 0; n < lat; n++) tick();
    bus.conv_valid = 1'b1;
    tick();
    bus.conv_valid = 1'b0;
    chk("done_pulse", 64'(bus.done), 64'(exp_done));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int n;
    rst = 1'b1;
    bus.req = '0;
    bus.conv_valid = 1'b0;
    tick();
    tick();
    chk("reset_gnt", 64'(bus.gnt), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_counters", {bus.jobs_done, bus.timeouts}, 64'd0);
    rst = 1'b0;

    // Single job from requester 2.
    bus.req = 4'b0100;
    tick();
    chk("single_start", 64'(bus.conv_start), 64'd1);
    chk("single_gnt", 64'(bus.gnt), 64'b0100);
    chk("single_src_sel", 64'(bus.src_sel), 64'd2);
    finish_job(10, 4'b0100);
    bus.req = '0;
    tick();
    chk("single_jobs_done", 64'(bus.jobs_done), 64'd1);

    // Round-robin fairness from a fresh pointer.
    do_reset();
    bus.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_start();
      chk("rr_order", 64'(bus.src_sel), 64'(exp_order[j]));
      finish_job(5, 4'(1 << exp_order[j]));
    end
    bus.req = '0;
    tick();
    chk("rr_jobs_done", 64'(bus.jobs_done), 64'd5);

    // Watchdog expiry for requester 1.
    bus.req = 4'b0010;
    wait_start();
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.err_timeout && n < 40);
    chk("timeout_after_wait_entry", 64'(n - 1), 64'd16);
    chk("timeout_err_id", 64'(bus.err_id), 64'd1);
    chk("timeout_no_done", 64'(bus.done), 64'd0);
    bus.req = '0;
    tick();
    chk("timeout_count", 64'(bus.timeouts), 64'd1);
    chk("timeout_idle", 64'(bus.busy), 64'd0);

    // Completion on the last watchdog cycle wins.
    bus.req = 4'b0001;
    wait_start();
    finish_job(16, 4'b0001);
    chk("tie_no_err", 64'(bus.err_timeout), 64'd0);
    bus.req = '0;
    tick();

    // Reset in the middle of a job.
    bus.req = 4'b0100;
    wait_start();
    tick(); tick(); tick();
    rst = 1'b1;
    bus.req = '0;
    #1;
    chk("midreset_outputs", {bus.gnt, bus.src_sel, bus.conv_start, bus.busy, bus.jobs_done},
        64'd0);
    tick();
    tick();
    rst = 1'b0;
    bus.conv_valid = 1'b1;
    tick();
    bus.conv_valid = 1'b0;
    chk("stale_valid_ignored", {bus.busy, bus.done}, 64'd0);
    tick();
    bus.req = 4'b1000;
    wait_start();
    chk("post_reset_gnt", 64'(bus.gnt), 64'b1000);
    chk("post_reset_src_sel", 64'(bus.src_sel), 64'd3);
    tick();
    bus.req = '0;
    finish_job(4, 4'b1000);
    tick();
    chk("post_reset_jobs", 64'(bus.jobs_done), 64'd1);

    // Timeout counter saturation.
    bus.req = 4'b0010;
    for (int t = 0; t < 257; t++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!bus.err_timeout && n < 40);
      if (!bus.err_timeout) begin
        chk("sat_wait_expired", 64'd0, 64'd1);
        break;
      end
    end
    bus.req = '0;
    tick();
    tick();
    chk("timeouts_saturated", 64'(bus.timeouts), 64'd255);
    chk("sat_err_id", 64'(bus.err_id), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
